// File: rtl/sim_pcie_sink.sv
// sim_pcie_sink: AXI write sink that checks burst length and returns delayed B responses.
// Define SIM_PCIE_SINK_READ_EN to add an address-pattern read responder.
module sim_pcie_sink #(
  parameter int DW    = 512,
  parameter int AW    = 64,
  parameter int IDW   = 4,
  parameter int DEPTH = 8,
  parameter int BLAT  = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [AW-1:0]     S_AXI_AWADDR,
  input  logic [7:0]        S_AXI_AWLEN,
  input  logic [IDW-1:0]    S_AXI_AWID,
  input  logic              S_AXI_AWVALID,
  input  logic [2:0]        S_AXI_AWSIZE,
  input  logic [1:0]        S_AXI_AWBURST,
  input  logic              S_AXI_AWLOCK,
  input  logic [3:0]        S_AXI_AWCACHE,
  input  logic [3:0]        S_AXI_AWQOS,
  input  logic [2:0]        S_AXI_AWPROT,
  output logic              S_AXI_AWREADY,
  input  logic [DW-1:0]     S_AXI_WDATA,
  input  logic [DW/8-1:0]   S_AXI_WSTRB,
  input  logic              S_AXI_WVALID,
  input  logic              S_AXI_WLAST,
  output logic              S_AXI_WREADY,
  output logic [IDW-1:0]    S_AXI_BID,
  output logic [1:0]        S_AXI_BRESP,
  output logic              S_AXI_BVALID,
  input  logic              S_AXI_BREADY,
  input  logic [AW-1:0]     S_AXI_ARADDR,
  input  logic [7:0]        S_AXI_ARLEN,
  input  logic [IDW-1:0]    S_AXI_ARID,
  input  logic              S_AXI_ARVALID,
  input  logic [2:0]        S_AXI_ARPROT,
  input  logic              S_AXI_ARLOCK,
  input  logic [1:0]        S_AXI_ARBURST,
  input  logic [3:0]        S_AXI_ARCACHE,
  input  logic [3:0]        S_AXI_ARQOS,
  output logic              S_AXI_ARREADY,
  output logic [DW-1:0]     S_AXI_RDATA,
  output logic [IDW-1:0]    S_AXI_RID,
  output logic [1:0]        S_AXI_RRESP,
  output logic              S_AXI_RLAST,
  output logic              S_AXI_RVALID,
  input  logic              S_AXI_RREADY,
  output logic [31:0]       bursts_rcvd,
  output logic [31:0]       beats_rcvd,
  output logic [15:0]       len_errors
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] P1 = {{PW{1'b0}}, 1'b1};

  logic [IDW-1:0] aq_id  [DEPTH];
  logic [7:0]     aq_len [DEPTH];
  logic [PW:0]    aq_wp;
  logic [PW:0]    aq_rp;
  logic [IDW-1:0] bq_id   [DEPTH];
  logic [1:0]     bq_resp [DEPTH];
  logic [7:0]     bq_tmr  [DEPTH];
  logic [PW:0]    bq_wp;
  logic [PW:0]    bq_rp;
  logic [31:0]    beat_cnt;

  logic [PW-1:0] aq_h;
  logic [PW-1:0] bq_h;
  logic aq_full;
  logic aq_empty;
  logic bq_full;
  logic bq_empty;
  logic aw_hs;
  logic w_hs;
  logic wl_hs;
  logic b_hs;
  logic len_ok;

  assign aq_h     = aq_rp[PW-1:0];
  assign bq_h     = bq_rp[PW-1:0];
  assign aq_empty = aq_wp == aq_rp;
  assign bq_empty = bq_wp == bq_rp;
  assign aq_full  = (aq_wp[PW] != aq_rp[PW]) && (aq_wp[PW-1:0] == aq_h);
  assign bq_full  = (bq_wp[PW] != bq_rp[PW]) && (bq_wp[PW-1:0] == bq_h);

  assign S_AXI_AWREADY = resetn & ~aq_full;
  assign S_AXI_WREADY  = resetn & ~aq_empty & ~bq_full;
  assign S_AXI_BVALID  = resetn & ~bq_empty & (bq_tmr[bq_h] == 8'd0);
  assign S_AXI_BID     = bq_id[bq_h];
  assign S_AXI_BRESP   = bq_resp[bq_h];

  assign aw_hs = S_AXI_AWVALID & S_AXI_AWREADY;
  assign w_hs  = S_AXI_WVALID & S_AXI_WREADY;
  assign wl_hs = w_hs & S_AXI_WLAST;
  assign b_hs  = S_AXI_BVALID & S_AXI_BREADY;
  // beat_cnt holds beats before this one, so a match means AWLEN+1 total
  assign len_ok = beat_cnt == {24'd0, aq_len[aq_h]};

  always_ff @(posedge clk) begin
    if (!resetn) begin
      aq_wp       <= '0;
      aq_rp       <= '0;
      bq_wp       <= '0;
      bq_rp       <= '0;
      beat_cnt    <= '0;
      bursts_rcvd <= '0;
      beats_rcvd  <= '0;
      len_errors  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        aq_id[i]   <= '0;
        aq_len[i]  <= '0;
        bq_id[i]   <= '0;
        bq_resp[i] <= '0;
        bq_tmr[i]  <= '0;
      end
    end else begin
      if (aw_hs) begin
        aq_id[aq_wp[PW-1:0]]  <= S_AXI_AWID;
        aq_len[aq_wp[PW-1:0]] <= S_AXI_AWLEN;
        aq_wp                 <= aq_wp + P1;
      end
      for (int i = 0; i < DEPTH; i++) begin
        if (bq_tmr[i] != 8'd0) bq_tmr[i] <= bq_tmr[i] - 8'd1;
      end
      if (w_hs) begin
        beats_rcvd <= beats_rcvd + 32'd1;
        beat_cnt   <= beat_cnt + 32'd1;
      end
      if (wl_hs) begin
        aq_rp                  <= aq_rp + P1;
        bq_id[bq_wp[PW-1:0]]   <= aq_id[aq_h];
        bq_resp[bq_wp[PW-1:0]] <= len_ok ? 2'b00 : 2'b10;
        bq_tmr[bq_wp[PW-1:0]]  <= 8'(BLAT);
        bq_wp                  <= bq_wp + P1;
        beat_cnt               <= '0;
        bursts_rcvd            <= bursts_rcvd + 32'd1;
        if (!len_ok && len_errors != 16'hFFFF)
          len_errors <= len_errors + 16'd1;
      end
      if (b_hs) bq_rp <= bq_rp + P1;
    end
  end

  logic unused;

`ifdef SIM_PCIE_SINK_READ_EN
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] BURST = 1'b1;

  logic [0:0]     state;
  logic [AW-1:0]  raddr;
  logic [7:0]     rlen;
  logic [7:0]     rbeat;
  logic [IDW-1:0] rid;
  logic [63:0]    lane;
  logic           busy;

  assign busy = resetn & (state == BURST);
  assign lane = 64'(raddr) + 64'(rbeat) * 64'(DW / 8);

  assign S_AXI_ARREADY = resetn & (state == IDLE);
  assign S_AXI_RVALID  = busy;
  assign S_AXI_RLAST   = busy & (rbeat == rlen);
  assign S_AXI_RDATA   = busy ? {(DW / 64){lane}} : '0;
  assign S_AXI_RID     = rid;
  assign S_AXI_RRESP   = 2'b00;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
      raddr <= '0;
      rlen  <= '0;
      rbeat <= '0;
      rid   <= '0;
    end else begin
      unique case (1'b1)
        (state == IDLE): begin
          if (S_AXI_ARVALID) begin
            raddr <= S_AXI_ARADDR;
            rlen  <= S_AXI_ARLEN;
            rid   <= S_AXI_ARID;
            rbeat <= '0;
            state <= BURST;
          end
        end
        (state == BURST): begin
          if (S_AXI_RREADY) begin
            if (rbeat == rlen) state <= IDLE;
            else rbeat <= rbeat + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign unused = ^{S_AXI_ARPROT, S_AXI_ARLOCK, S_AXI_ARBURST,
                    S_AXI_ARCACHE, S_AXI_ARQOS};
`else
  assign S_AXI_ARREADY = 1'b0;
  assign S_AXI_RVALID  = 1'b0;
  assign S_AXI_RLAST   = 1'b0;
  assign S_AXI_RDATA   = '0;
  assign S_AXI_RID     = '0;
  assign S_AXI_RRESP   = 2'b00;

  assign unused = ^{S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARID, S_AXI_ARVALID,
                    S_AXI_ARPROT, S_AXI_ARLOCK, S_AXI_ARBURST,
                    S_AXI_ARCACHE, S_AXI_ARQOS, S_AXI_RREADY};
`endif

  logic unused_w;
  assign unused_w = ^{S_AXI_AWADDR, S_AXI_AWSIZE, S_AXI_AWBURST,
                      S_AXI_AWLOCK, S_AXI_AWCACHE, S_AXI_AWQOS,
                      S_AXI_AWPROT, S_AXI_WDATA, S_AXI_WSTRB};

endmodule

// File: tb/tb_sim_pcie_sink.sv
// tb_sim_pcie_sink: random AXI write traffic against a queue/timestamp model,
// plus read-responder checks when SIM_PCIE_SINK_READ_EN is defined.
module tb_sim_pcie_sink;
  localparam int DW    = 512;
  localparam int AW    = 64;
  localparam int IDW   = 4;
  localparam int DEPTH = 8;
  localparam int BLAT  = 4;

  logic            clk;
  logic            resetn;
  logic [AW-1:0]   S_AXI_AWADDR;
  logic [7:0]      S_AXI_AWLEN;
  logic [IDW-1:0]  S_AXI_AWID;
  logic            S_AXI_AWVALID;
  logic            S_AXI_AWREADY;
  logic [DW-1:0]   S_AXI_WDATA;
  logic [DW/8-1:0] S_AXI_WSTRB;
  logic            S_AXI_WVALID;
  logic            S_AXI_WLAST;
  logic            S_AXI_WREADY;
  logic [IDW-1:0]  S_AXI_BID;
  logic [1:0]      S_AXI_BRESP;
  logic            S_AXI_BVALID;
  logic            S_AXI_BREADY;
  logic [AW-1:0]   S_AXI_ARADDR;
  logic [7:0]      S_AXI_ARLEN;
  logic [IDW-1:0]  S_AXI_ARID;
  logic            S_AXI_ARVALID;
  logic            S_AXI_ARREADY;
  logic [DW-1:0]   S_AXI_RDATA;
  logic [IDW-1:0]  S_AXI_RID;
  logic [1:0]      S_AXI_RRESP;
  logic            S_AXI_RLAST;
  logic            S_AXI_RVALID;
  logic            S_AXI_RREADY;
  logic [31:0]     bursts_rcvd;
  logic [31:0]     beats_rcvd;
  logic [15:0]     len_errors;

  sim_pcie_sink #(
    .DW(DW), .AW(AW), .IDW(IDW), .DEPTH(DEPTH), .BLAT(BLAT)
  ) dut (
    .clk(clk), .resetn(resetn),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWLEN(S_AXI_AWLEN),
    .S_AXI_AWID(S_AXI_AWID), .S_AXI_AWVALID(S_AXI_AWVALID),
    .S_AXI_AWSIZE(3'd6), .S_AXI_AWBURST(2'd1), .S_AXI_AWLOCK(1'b0),
    .S_AXI_AWCACHE(4'd0), .S_AXI_AWQOS(4'd0), .S_AXI_AWPROT(3'd0),
    .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WLAST(S_AXI_WLAST),
    .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BID(S_AXI_BID), .S_AXI_BRESP(S_AXI_BRESP),
    .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARLEN(S_AXI_ARLEN),
    .S_AXI_ARID(S_AXI_ARID), .S_AXI_ARVALID(S_AXI_ARVALID),
    .S_AXI_ARPROT(3'd0), .S_AXI_ARLOCK(1'b0), .S_AXI_ARBURST(2'd1),
    .S_AXI_ARCACHE(4'd0), .S_AXI_ARQOS(4'd0),
    .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RID(S_AXI_RID),
    .S_AXI_RRESP(S_AXI_RRESP), .S_AXI_RLAST(S_AXI_RLAST),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .bursts_rcvd(bursts_rcvd), .beats_rcvd(beats_rcvd),
    .len_errors(len_errors)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [IDW-1:0] id; logic [7:0] len; } aw_t;
  typedef struct { logic [IDW-1:0] id; logic [1:0] resp; int rel; } b_t;

  aw_t awq[$];
  b_t  bq[$];
  int  cyc;
  int  mcnt;
  int  mbursts;
  int  mbeats;
  int  mlenerr;
  int  tgt;
  bit  tgt_set;
  int  n_chk;
  int  n_err;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    awq.delete();
    bq.delete();
    mcnt    = 0;
    mbursts = 0;
    mbeats  = 0;
    mlenerr = 0;
    tgt_set = 0;
  endtask

  // Compare one cycle at the negedge, then advance the model at the posedge
  task automatic cycle();
    logic e_awr, e_wr, e_bv, err;
    b_t   nb;
    @(negedge clk);
    e_awr = resetn && awq.size() < DEPTH;
    e_wr  = resetn && awq.size() > 0 && bq.size() < DEPTH;
    e_bv  = resetn && bq.size() > 0 && cyc >= bq[0].rel;
    check("awready", 64'(S_AXI_AWREADY), 64'(e_awr));
    check("wready", 64'(S_AXI_WREADY), 64'(e_wr));
    check("bvalid", 64'(S_AXI_BVALID), 64'(e_bv));
    if (e_bv) begin
      check("bid", 64'(S_AXI_BID), 64'(bq[0].id));
      check("bresp", 64'(S_AXI_BRESP), 64'(bq[0].resp));
    end
    check("bursts_rcvd", 64'(bursts_rcvd), 64'(32'(mbursts)));
    check("beats_rcvd", 64'(beats_rcvd), 64'(32'(mbeats)));
    check("len_errors", 64'(len_errors), 64'(16'(mlenerr)));
    @(posedge clk);
    cyc++;
    if (!resetn) begin
      model_clear();
    end else begin
      if (S_AXI_AWVALID && e_awr)
        awq.push_back('{id: S_AXI_AWID, len: S_AXI_AWLEN});
      if (S_AXI_WVALID && e_wr) begin
        mbeats++;
        if (S_AXI_WLAST) begin
          err = (mcnt + 1) != (int'(awq[0].len) + 1);
          nb.id   = awq[0].id;
          nb.resp = err ? 2'b10 : 2'b00;
          nb.rel  = cyc + BLAT;
          bq.push_back(nb);
          if (err && mlenerr < 65535) mlenerr++;
          mbursts++;
          void'(awq.pop_front());
          mcnt    = 0;
          tgt_set = 0;
        end else begin
          mcnt++;
        end
      end
      if (S_AXI_BREADY && e_bv) void'(bq.pop_front());
    end
    #1;
  endtask

  task automatic drive(input int aw_pct, input int w_pct, input int b_pct);
    S_AXI_AWVALID = $urandom_range(99) < aw_pct;
    S_AXI_AWID    = IDW'($urandom);
    S_AXI_AWLEN   = 8'($urandom_range(7));
    S_AXI_AWADDR  = {$urandom, $urandom};
    S_AXI_WVALID  = $urandom_range(99) < w_pct;
    S_AXI_WDATA   = {(DW / 32){$urandom}};
    S_AXI_WSTRB   = '1;
    if (!tgt_set && awq.size() > 0) begin
      // mostly correct lengths, sometimes short or overlong bursts
      if ($urandom_range(3) != 0) tgt = int'(awq[0].len) + 1;
      else tgt = $urandom_range(int'(awq[0].len) + 3, 1);
      tgt_set = 1;
    end
    if (awq.size() > 0) S_AXI_WLAST = (mcnt + 1) >= tgt;
    else S_AXI_WLAST = 1'($urandom_range(1));
    S_AXI_BREADY = $urandom_range(99) < b_pct;
  endtask

  task automatic phase(input int n, input int aw_pct, input int w_pct,
                       input int b_pct, input int rst_at);
    for (int i = 0; i < n; i++) begin
      drive(aw_pct, w_pct, b_pct);
      resetn = (i != rst_at);
      cycle();
    end
    resetn = 1'b1;
  endtask

`ifdef SIM_PCIE_SINK_READ_EN
  task automatic rd_burst(input logic [63:0] addr, input int len,
                          input logic [IDW-1:0] id);
    int beat;
    bit done;
    logic [63:0] exp;
    beat = 0;
    done = 0;
    S_AXI_ARADDR  = addr;
    S_AXI_ARLEN   = 8'(len);
    S_AXI_ARID    = id;
    S_AXI_ARVALID = 1'b1;
    S_AXI_RREADY  = 1'b0;
    @(negedge clk);
    check("arready", 64'(S_AXI_ARREADY), 64'd1);
    check("rvalid_idle", 64'(S_AXI_RVALID), 64'd0);
    @(posedge clk);
    #1;
    S_AXI_ARVALID = 1'b0;
    for (int c = 0; c < 64 && !done; c++) begin
      S_AXI_RREADY = (c % 2) == 1;
      @(negedge clk);
      exp = addr + 64'(beat) * 64'(DW / 8);
      check("rvalid", 64'(S_AXI_RVALID), 64'd1);
      check("arready_busy", 64'(S_AXI_ARREADY), 64'd0);
      check("rid", 64'(S_AXI_RID), 64'(id));
      check("rresp", 64'(S_AXI_RRESP), 64'd0);
      check("rlast", 64'(S_AXI_RLAST), 64'(beat == len));
      check("rdata_lo", S_AXI_RDATA[63:0], exp);
      check("rdata_hi", S_AXI_RDATA[DW-1 -: 64], exp);
      @(posedge clk);
      if (S_AXI_RREADY) begin
        if (beat == len) done = 1;
        beat++;
      end
      #1;
    end
    if (!done) check("rd_timeout", 64'd0, 64'd1);
    S_AXI_RREADY = 1'b0;
    @(negedge clk);
    check("rvalid_end", 64'(S_AXI_RVALID), 64'd0);
    check("arready_end", 64'(S_AXI_ARREADY), 64'd1);
    @(posedge clk);
    #1;
  endtask
`endif

  initial begin
    n_chk = 0;
    n_err = 0;
    cyc   = 0;
    model_clear();
    resetn        = 1'b0;
    S_AXI_AWVALID = 1'b0;
    S_AXI_AWADDR  = '0;
    S_AXI_AWLEN   = '0;
    S_AXI_AWID    = '0;
    S_AXI_WVALID  = 1'b0;
    S_AXI_WLAST   = 1'b0;
    S_AXI_WDATA   = '0;
    S_AXI_WSTRB   = '0;
    S_AXI_BREADY  = 1'b0;
    S_AXI_ARVALID = 1'b0;
    S_AXI_ARADDR  = '0;
    S_AXI_ARLEN   = '0;
    S_AXI_ARID    = '0;
    S_AXI_RREADY  = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) cycle();
    check("rvalid_rst", 64'(S_AXI_RVALID), 64'd0);
    check("arready_rst", 64'(S_AXI_ARREADY), 64'd0);
    resetn = 1'b1;

    phase(300, 50, 70, 80, -1);
    phase(12, 100, 0, 100, -1);
    phase(30, 0, 100, 0, -1);
    phase(25, 0, 0, 100, -1);
    phase(200, 60, 80, 50, 120);
    phase(300, 40, 90, 30, -1);
    phase(40, 0, 100, 100, -1);

    S_AXI_AWVALID = 1'b0;
    S_AXI_WVALID  = 1'b0;
    S_AXI_BREADY  = 1'b1;
    for (int i = 0; i < 20; i++) cycle();

`ifdef SIM_PCIE_SINK_READ_EN
    rd_burst(64'h1000, 1, 4'd5);
    rd_burst({$urandom, $urandom}, $urandom_range(6), IDW'($urandom));
`else
    S_AXI_ARVALID = 1'b1;
    S_AXI_RREADY  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("arready_off", 64'(S_AXI_ARREADY), 64'd0);
      check("rvalid_off", 64'(S_AXI_RVALID), 64'd0);
      check("rlast_off", 64'(S_AXI_RLAST), 64'd0);
      check("rdata_off", S_AXI_RDATA[63:0], 64'd0);
      check("rid_off", 64'(S_AXI_RID), 64'd0);
      @(posedge clk);
      #1;
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
